// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush sequencer: FSM states,
// pipeline-register indices and the hard-wired zero register id.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FLUSH    = 2'd2
    } state_t;

    // Bit positions of each pipeline register in the internal we/clr vectors
    localparam int STG_IFID  = 0;
    localparam int STG_IDEX  = 1;
    localparam int STG_EXMEM = 2;
    localparam int STG_MEMWB = 3;
    localparam int NUM_STG   = 4;

    localparam int ZERO_REG_ID = 0;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational load-use detector: a load in EX whose destination is read by
// the instruction currently in ID.
module pipeline_ctrl_hazard_detect
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned REG_W = 6
) (
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [REG_W-1:0] ex_reg_dest,
    input  logic             ex_reg_write,
    input  logic             ex_mem_to_reg,
    output logic             load_use
);

    logic ex_is_load;
    logic rs_hit;
    logic rt_hit;

    // Writes to the zero register are discarded, so they never create a hazard
    assign ex_is_load = ex_mem_to_reg & ex_reg_write &
                        (ex_reg_dest != REG_W'(ZERO_REG_ID));
    assign rs_hit     = id_use_rs & (id_rs == ex_reg_dest);
    assign rt_hit     = id_use_rt & (id_rt == ex_reg_dest);
    assign load_use   = ex_is_load & (rs_hit | rt_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: drives pipeline-register
// write enables/clears and PC control, with bus-wait timeout and stall counting.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned REG_W   = 6,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [REG_W-1:0] ex_reg_dest,
    input  logic             ex_reg_write,
    input  logic             ex_mem_to_reg,
    input  logic             if_req,
    input  logic             if_ack,
    input  logic             mem_req,
    input  logic             mem_ack,
    input  logic             exc_valid,
    output logic             pc_we,
    output logic             pc_sel_exc,
    output logic             if_id_we,
    output logic             if_id_clr,
    output logic             id_ex_we,
    output logic             id_ex_clr,
    output logic             ex_mem_we,
    output logic             ex_mem_clr,
    output logic             mem_wb_we,
    output logic             mem_wb_clr,
    output logic             bus_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned TO_W = $clog2(TIMEOUT) + 1;

    state_t             state_q, state_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic               load_use;
    logic               mem_stall;
    logic               fetch_miss;
    logic [NUM_STG-1:0] we_c;
    logic [NUM_STG-1:0] clr_c;
    logic               pc_we_c;
    logic               pc_sel_c;
    logic               bus_err_c;

    pipeline_ctrl_hazard_detect #(
        .REG_W(REG_W)
    ) u_hazard (
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_use_rs     (id_use_rs),
        .id_use_rt     (id_use_rt),
        .ex_reg_dest   (ex_reg_dest),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_to_reg (ex_mem_to_reg),
        .load_use      (load_use)
    );

    assign mem_stall  = mem_req & ~mem_ack;
    assign fetch_miss = if_req & ~if_ack;

    always_comb begin
        state_d   = state_q;
        to_cnt_d  = to_cnt_q;
        we_c      = '1;
        clr_c     = '0;
        pc_we_c   = 1'b1;
        pc_sel_c  = 1'b0;
        bus_err_c = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (exc_valid) begin
                    clr_c   = '1;
                    pc_we_c = 1'b0;
                    state_d = ST_FLUSH;
                end else if (mem_stall) begin
                    pc_we_c          = 1'b0;
                    we_c[STG_IFID]   = 1'b0;
                    we_c[STG_IDEX]   = 1'b0;
                    we_c[STG_EXMEM]  = 1'b0;
                    clr_c[STG_MEMWB] = 1'b1;
                    state_d          = ST_MEM_WAIT;
                    to_cnt_d         = TO_W'(1);
                end else if (load_use) begin
                    pc_we_c         = 1'b0;
                    we_c[STG_IFID]  = 1'b0;
                    clr_c[STG_IDEX] = 1'b1;
                end else if (fetch_miss) begin
                    pc_we_c         = 1'b0;
                    clr_c[STG_IFID] = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                // An ack arriving on the timeout cycle still completes the access
                if (mem_ack) begin
                    state_d  = ST_RUN;
                    to_cnt_d = '0;
                end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                    bus_err_c = 1'b1;
                    clr_c     = '1;
                    pc_we_c   = 1'b0;
                    state_d   = ST_FLUSH;
                    to_cnt_d  = '0;
                end else begin
                    pc_we_c          = 1'b0;
                    we_c[STG_IFID]   = 1'b0;
                    we_c[STG_IDEX]   = 1'b0;
                    we_c[STG_EXMEM]  = 1'b0;
                    clr_c[STG_MEMWB] = 1'b1;
                    to_cnt_d         = to_cnt_q + TO_W'(1);
                end
            end
            ST_FLUSH: begin
                pc_sel_c        = 1'b1;
                clr_c[STG_IFID] = 1'b1;
                state_d         = ST_RUN;
            end
            default: begin
                state_d  = ST_RUN;
                to_cnt_d = '0;
            end
        endcase
    end

    assign stall_cnt_d = pc_we_c ? stall_cnt_q : stall_cnt_q + CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            to_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            to_cnt_q    <= to_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Reset forces every control output low without waiting for a clock
    assign pc_we      = pc_we_c   & ~rst;
    assign pc_sel_exc = pc_sel_c  & ~rst;
    assign bus_err    = bus_err_c & ~rst;
    assign if_id_we   = we_c[STG_IFID]   & ~rst;
    assign id_ex_we   = we_c[STG_IDEX]   & ~rst;
    assign ex_mem_we  = we_c[STG_EXMEM]  & ~rst;
    assign mem_wb_we  = we_c[STG_MEMWB]  & ~rst;
    assign if_id_clr  = clr_c[STG_IFID]  & ~rst;
    assign id_ex_clr  = clr_c[STG_IDEX]  & ~rst;
    assign ex_mem_clr = clr_c[STG_EXMEM] & ~rst;
    assign mem_wb_clr = clr_c[STG_MEMWB] & ~rst;
    assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scenario bench for pipeline_ctrl: per-cycle stimulus rows carry the expected
// control vector, which is queued when driven and compared mid-cycle.
module tb_pipeline_ctrl;

    localparam logic Y = 1'b1;
    localparam logic N = 1'b0;

    // {pc_we, pc_sel_exc, we[ifid,idex,exmem,memwb], clr[ifid,idex,exmem,memwb], bus_err}
    localparam logic [10:0] ZERO   = 11'b0_0_0000_0000_0;
    localparam logic [10:0] ADV    = 11'b1_0_1111_0000_0;
    localparam logic [10:0] EXC    = 11'b0_0_1111_1111_0;
    localparam logic [10:0] MSTALL = 11'b0_0_0001_0001_0;
    localparam logic [10:0] LU     = 11'b0_0_0111_0100_0;
    localparam logic [10:0] MISS   = 11'b0_0_1111_1000_0;
    localparam logic [10:0] TOUT   = 11'b0_0_1111_1111_1;
    localparam logic [10:0] FLUSH  = 11'b1_1_1111_1000_0;

    typedef struct packed {
        logic        rst;
        logic        ld;
        logic [5:0]  dest;
        logic [5:0]  rs;
        logic        urs;
        logic [5:0]  rt;
        logic        urt;
        logic        ireq;
        logic        iack;
        logic        mreq;
        logic        mack;
        logic        exc;
        logic [10:0] exp;
    } st_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  id_rs = '0, id_rt = '0, ex_reg_dest = '0;
    logic        id_use_rs = 1'b0, id_use_rt = 1'b0;
    logic        ex_reg_write = 1'b0, ex_mem_to_reg = 1'b0;
    logic        if_req = 1'b0, if_ack = 1'b0, mem_req = 1'b0, mem_ack = 1'b0;
    logic        exc_valid = 1'b0;
    logic        pc_we, pc_sel_exc, bus_err;
    logic        if_id_we, if_id_clr, id_ex_we, id_ex_clr;
    logic        ex_mem_we, ex_mem_clr, mem_wb_we, mem_wb_clr;
    logic [31:0] stall_cnt;

    st_t   stq[$];
    string nmq[$];
    st_t   sb[$];
    string sbn[$];
    st_t   cur;
    string cur_nm;
    int    n_cmp  = 0;
    int    n_fail = 0;
    logic [31:0] exp_stall = '0;

    pipeline_ctrl #(.REG_W(6), .TIMEOUT(4), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .ex_reg_dest(ex_reg_dest), .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
        .if_req(if_req), .if_ack(if_ack), .mem_req(mem_req), .mem_ack(mem_ack),
        .exc_valid(exc_valid),
        .pc_we(pc_we), .pc_sel_exc(pc_sel_exc),
        .if_id_we(if_id_we), .if_id_clr(if_id_clr), .id_ex_we(id_ex_we), .id_ex_clr(id_ex_clr),
        .ex_mem_we(ex_mem_we), .ex_mem_clr(ex_mem_clr), .mem_wb_we(mem_wb_we), .mem_wb_clr(mem_wb_clr),
        .bus_err(bus_err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [10:0] outv();
        return {pc_we, pc_sel_exc, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
                if_id_clr, id_ex_clr, ex_mem_clr, mem_wb_clr, bus_err};
    endfunction

    task automatic add(input string nm, input logic [10:0] e, input logic r, input logic ld,
                       input logic [5:0] dest, input logic [5:0] rs, input logic urs,
                       input logic [5:0] rt, input logic urt, input logic ireq, input logic iack,
                       input logic mreq, input logic mack, input logic exc);
        st_t s;
        s.rst = r; s.ld = ld; s.dest = dest; s.rs = rs; s.urs = urs; s.rt = rt; s.urt = urt;
        s.ireq = ireq; s.iack = iack; s.mreq = mreq; s.mack = mack; s.exc = exc; s.exp = e;
        stq.push_back(s);
        nmq.push_back(nm);
    endtask

    task automatic add_idle(input string nm, input logic [10:0] e);
        add(nm, e, N, N, 6'd0, 6'd0, N, 6'd0, N, N, N, N, N, N);
    endtask

    task automatic add_mstall(input string nm, input logic [10:0] e, input logic exc);
        add(nm, e, N, Y, 6'd4, 6'd4, Y, 6'd0, N, Y, N, Y, N, exc);
    endtask

    // Drive the next row on the falling edge and queue its expectation
    task automatic drive_next();
        st_t s;
        s = stq.pop_front();
        @(negedge clk);
        rst = s.rst; ex_mem_to_reg = s.ld; ex_reg_write = s.ld; ex_reg_dest = s.dest;
        id_rs = s.rs; id_use_rs = s.urs; id_rt = s.rt; id_use_rt = s.urt;
        if_req = s.ireq; if_ack = s.iack; mem_req = s.mreq; mem_ack = s.mack; exc_valid = s.exc;
        sb.push_back(s);
        sbn.push_back(nmq.pop_front());
        #2;
    endtask

    task automatic test_reset();
        add("rst_hold", ZERO, Y, Y, 6'd5, 6'd5, Y, 6'd0, N, Y, N, Y, N, Y);
        add("rst_hold2", ZERO, Y, N, 6'd0, 6'd0, N, 6'd0, N, Y, N, N, N, N);
        add_idle("rst_release_adv", ADV);
        while (stq.size() > 0) begin
            drive_next();
            cur = sb.pop_front(); cur_nm = sbn.pop_front();
            n_cmp++;
            if (outv() !== cur.exp) begin n_fail++; $display("FAIL %s: outputs %b, expected %b", cur_nm, outv(), cur.exp); end
            n_cmp++;
            if (stall_cnt !== exp_stall) begin n_fail++; $display("FAIL %s_stall_cnt: got %0d, expected %0d", cur_nm, stall_cnt, exp_stall); end
            if (!cur.rst && !cur.exp[10]) exp_stall++;
        end
    endtask

    task automatic test_load_use();
        add("lu_rs", LU, N, Y, 6'd5, 6'd5, Y, 6'd1, N, N, N, N, N, N);
        add_idle("lu_after_adv", ADV);
        add("lu_dest0", ADV, N, Y, 6'd0, 6'd0, Y, 6'd0, Y, N, N, N, N, N);
        add("lu_rt", LU, N, Y, 6'd7, 6'd3, Y, 6'd7, Y, N, N, N, N, N);
        add("lu_unused_src", ADV, N, Y, 6'd7, 6'd7, N, 6'd7, N, N, N, N, N, N);
        add("lu_not_load", ADV, N, N, 6'd7, 6'd7, Y, 6'd0, N, N, N, N, N, N);
        add("lu_beats_miss", LU, N, Y, 6'd9, 6'd9, Y, 6'd0, N, Y, N, N, N, N);
        add("fetch_miss", MISS, N, N, 6'd0, 6'd0, N, 6'd0, N, Y, N, N, N, N);
        add("fetch_hit", ADV, N, N, 6'd0, 6'd0, N, 6'd0, N, Y, Y, N, N, N);
        while (stq.size() > 0) begin
            drive_next();
            cur = sb.pop_front(); cur_nm = sbn.pop_front();
            n_cmp++;
            if (outv() !== cur.exp) begin n_fail++; $display("FAIL %s: outputs %b, expected %b", cur_nm, outv(), cur.exp); end
            n_cmp++;
            if (stall_cnt !== exp_stall) begin n_fail++; $display("FAIL %s_stall_cnt: got %0d, expected %0d", cur_nm, stall_cnt, exp_stall); end
            if (!cur.rst && !cur.exp[10]) exp_stall++;
        end
    endtask

    task automatic test_mem_wait();
        add_mstall("mw_enter", MSTALL, N);
        add_mstall("mw_wait1_exc_ignored", MSTALL, Y);
        add_mstall("mw_wait2", MSTALL, N);
        add("mw_ack", ADV, N, N, 6'd0, 6'd0, N, 6'd0, N, N, N, Y, Y, N);
        add_idle("mw_after", ADV);
        add("mw_prio_over_lu", MSTALL, N, Y, 6'd6, 6'd6, Y, 6'd0, N, Y, N, Y, N, N);
        add("mw_ack2", ADV, N, N, 6'd0, 6'd0, N, 6'd0, N, N, N, Y, Y, N);
        while (stq.size() > 0) begin
            drive_next();
            cur = sb.pop_front(); cur_nm = sbn.pop_front();
            n_cmp++;
            if (outv() !== cur.exp) begin n_fail++; $display("FAIL %s: outputs %b, expected %b", cur_nm, outv(), cur.exp); end
            n_cmp++;
            if (stall_cnt !== exp_stall) begin n_fail++; $display("FAIL %s_stall_cnt: got %0d, expected %0d", cur_nm, stall_cnt, exp_stall); end
            if (!cur.rst && !cur.exp[10]) exp_stall++;
        end
    endtask

    task automatic test_timeout();
        add_mstall("to_enter", MSTALL, N);
        add_mstall("to_wait1", MSTALL, N);
        add_mstall("to_wait2", MSTALL, N);
        add_mstall("to_bus_err", TOUT, N);
        add_mstall("to_flush_ignores_inputs", FLUSH, Y);
        add_idle("to_resume", ADV);
        add_mstall("ack_race_enter", MSTALL, N);
        add_mstall("ack_race_wait1", MSTALL, N);
        add_mstall("ack_race_wait2", MSTALL, N);
        add("ack_beats_timeout", ADV, N, N, 6'd0, 6'd0, N, 6'd0, N, N, N, Y, Y, N);
        add_idle("ack_race_after", ADV);
        while (stq.size() > 0) begin
            drive_next();
            cur = sb.pop_front(); cur_nm = sbn.pop_front();
            n_cmp++;
            if (outv() !== cur.exp) begin n_fail++; $display("FAIL %s: outputs %b, expected %b", cur_nm, outv(), cur.exp); end
            n_cmp++;
            if (stall_cnt !== exp_stall) begin n_fail++; $display("FAIL %s_stall_cnt: got %0d, expected %0d", cur_nm, stall_cnt, exp_stall); end
            if (!cur.rst && !cur.exp[10]) exp_stall++;
        end
    endtask

    task automatic test_exception();
        add("exc_run", EXC, N, N, 6'd0, 6'd0, N, 6'd0, N, N, N, N, N, Y);
        add("exc_flush", FLUSH, N, N, 6'd0, 6'd0, N, 6'd0, N, Y, N, N, N, N);
        add_idle("exc_resume", ADV);
        add("exc_prio_all", EXC, N, Y, 6'd5, 6'd5, Y, 6'd0, N, Y, N, Y, N, Y);
        add_mstall("exc_prio_flush", FLUSH, N);
        add_idle("exc_prio_resume", ADV);
        while (stq.size() > 0) begin
            drive_next();
            cur = sb.pop_front(); cur_nm = sbn.pop_front();
            n_cmp++;
            if (outv() !== cur.exp) begin n_fail++; $display("FAIL %s: outputs %b, expected %b", cur_nm, outv(), cur.exp); end
            n_cmp++;
            if (stall_cnt !== exp_stall) begin n_fail++; $display("FAIL %s_stall_cnt: got %0d, expected %0d", cur_nm, stall_cnt, exp_stall); end
            if (!cur.rst && !cur.exp[10]) exp_stall++;
        end
    endtask

    task automatic test_back_to_back();
        add("b2b_lu1", LU, N, Y, 6'd8, 6'd8, Y, 6'd0, N, N, N, N, N, N);
        add("b2b_lu2", LU, N, Y, 6'd8, 6'd0, N, 6'd8, Y, N, N, N, N, N);
        add("b2b_exc1", EXC, N, N, 6'd0, 6'd0, N, 6'd0, N, N, N, N, N, Y);
        add("b2b_flush1", FLUSH, N, N, 6'd0, 6'd0, N, 6'd0, N, N, N, N, N, Y);
        add("b2b_exc2", EXC, N, N, 6'd0, 6'd0, N, 6'd0, N, N, N, N, N, Y);
        add("b2b_flush2", FLUSH, N, N, 6'd0, 6'd0, N, 6'd0, N, N, N, N, N, N);
        add_idle("b2b_resume", ADV);
        while (stq.size() > 0) begin
            drive_next();
            cur = sb.pop_front(); cur_nm = sbn.pop_front();
            n_cmp++;
            if (outv() !== cur.exp) begin n_fail++; $display("FAIL %s: outputs %b, expected %b", cur_nm, outv(), cur.exp); end
            n_cmp++;
            if (stall_cnt !== exp_stall) begin n_fail++; $display("FAIL %s_stall_cnt: got %0d, expected %0d", cur_nm, stall_cnt, exp_stall); end
            if (!cur.rst && !cur.exp[10]) exp_stall++;
        end
    endtask

    task automatic test_async_reset();
        add_mstall("ar_enter", MSTALL, N);
        add_mstall("ar_wait1", MSTALL, Y);
        while (stq.size() > 0) begin
            drive_next();
            cur = sb.pop_front(); cur_nm = sbn.pop_front();
            n_cmp++;
            if (outv() !== cur.exp) begin n_fail++; $display("FAIL %s: outputs %b, expected %b", cur_nm, outv(), cur.exp); end
            n_cmp++;
            if (stall_cnt !== exp_stall) begin n_fail++; $display("FAIL %s_stall_cnt: got %0d, expected %0d", cur_nm, stall_cnt, exp_stall); end
            if (!cur.rst && !cur.exp[10]) exp_stall++;
        end
        // Still in MEM_WAIT with exc_valid held: pulse reset between clock edges
        @(negedge clk);
        mem_req = 1'b1; mem_ack = 1'b0; exc_valid = 1'b1;
        ex_mem_to_reg = 1'b0; ex_reg_write = 1'b0; if_req = 1'b0;
        #2;
        n_cmp++;
        if (outv() !== MSTALL) begin n_fail++; $display("FAIL ar_pre_reset: outputs %b, expected %b", outv(), MSTALL); end
        rst = 1'b1;
        exp_stall = '0;
        #1;
        n_cmp++;
        if (outv() !== ZERO) begin n_fail++; $display("FAIL ar_outputs_low: outputs %b, expected %b", outv(), ZERO); end
        n_cmp++;
        if (stall_cnt !== exp_stall) begin n_fail++; $display("FAIL ar_stall_cnt_clear: got %0d, expected %0d", stall_cnt, exp_stall); end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (outv() !== EXC) begin n_fail++; $display("FAIL ar_state_run: outputs %b, expected %b", outv(), EXC); end
        exp_stall++;
        add_idle("ar_flush", FLUSH);
        add_mstall("ar_to_enter", MSTALL, N);
        add_mstall("ar_to_wait1", MSTALL, N);
        add_mstall("ar_to_wait2", MSTALL, N);
        add_mstall("ar_to_bus_err", TOUT, N);
        add_idle("ar_to_flush", FLUSH);
        add_idle("ar_to_resume", ADV);
        while (stq.size() > 0) begin
            drive_next();
            cur = sb.pop_front(); cur_nm = sbn.pop_front();
            n_cmp++;
            if (outv() !== cur.exp) begin n_fail++; $display("FAIL %s: outputs %b, expected %b", cur_nm, outv(), cur.exp); end
            n_cmp++;
            if (stall_cnt !== exp_stall) begin n_fail++; $display("FAIL %s_stall_cnt: got %0d, expected %0d", cur_nm, stall_cnt, exp_stall); end
            if (!cur.rst && !cur.exp[10]) exp_stall++;
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_mem_wait();
        test_timeout();
        test_exception();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
